ts_rx_checker: RTL and testbench

//  Receive-side checker for the 188-byte MPEG-TS byte stream (DATA/DVALID/PSYNC, DCLK=CLK_IN)

---
 rtl/ts_rx_checker.sv | 236 +++++++++++++++++++++++
 tb/tb_ts_rx_checker.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_rx_checker.sv
// MPEG-TS receive checker: acquires/tracks 188-byte packet sync, extracts PID/CC,
// checks CC sequence and test-pattern payload on one filtered PID, keeps error counters.
`timescale 1ns/1ps
module ts_rx_checker #(
   parameter int unsigned SYNC_LOCK   = 3,
   parameter int unsigned SYNC_LOSS   = 3,
   parameter int unsigned PAYLOAD_CHK = 1
) (
   input  logic        CLK_IN,
   input  logic        RST,
   input  logic [7:0]  DATA,
   input  logic        DVALID,
   input  logic        PSYNC,
   input  logic [12:0] PID_FILTER,
   input  logic        CLR_CNT,
   output logic        LOCKED,
   output logic [12:0] RX_PID,
   output logic [3:0]  RX_CC,
   output logic        PKT_STROBE,
   output logic        CC_ERR,
   output logic [31:0] PKT_CNT,
   output logic [15:0] CC_ERR_CNT,
   output logic [15:0] SYNC_ERR_CNT,
   output logic [15:0] PAY_ERR_CNT
);
   localparam int unsigned IDX_W = 8;
   localparam int unsigned RUN_W = 8;
   localparam int unsigned ERR_W = 16;
   localparam int unsigned PKT_W = 32;
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(187);
   localparam logic [7:0]       SYNC_BYTE = 8'h47;
   localparam logic [RUN_W-1:0] LOCK_N    = RUN_W'(SYNC_LOCK);
   localparam logic [RUN_W-1:0] LOSS_N    = RUN_W'(SYNC_LOSS);

   typedef enum logic [1:0] {HUNT, ACQ, LOCK} state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [RUN_W-1:0] good_q, good_d, bad_q, bad_d;
   logic [12:0]      pid_q, pid_d, filt_q, filt_d, rx_pid_q, rx_pid_d;
   logic [3:0]       cc_q, cc_d, ref_cc_q, ref_cc_d, rx_cc_q, rx_cc_d;
   logic             ref_vld_q, ref_vld_d, match_q, match_d, pay_flag_q, pay_flag_d;
   logic             locked_q, locked_d, strobe_q, strobe_d, cc_err_q, cc_err_d;
   logic [PKT_W-1:0] pkt_cnt_q, pkt_cnt_d;
   logic [ERR_W-1:0] cc_err_cnt_q, cc_err_cnt_d, sync_err_cnt_q, sync_err_cnt_d;
   logic [ERR_W-1:0] pay_err_cnt_q, pay_err_cnt_d;

   logic             good_sync_c, pay_bad_c, ref_ok_c;
   logic             inc_cc_c, inc_sync_c, inc_pay_c, inc_pkt_c;
   logic [IDX_W-1:0] idx_nxt_c;

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (v == '1) ? v : v + ERR_W'(1);
   endfunction

   // Next-state, header/CC/payload tracking and counter updates
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      good_d     = good_q;
      bad_d      = bad_q;
      pid_d      = pid_q;
      filt_d     = filt_q;
      rx_pid_d   = rx_pid_q;
      cc_d       = cc_q;
      ref_cc_d   = ref_cc_q;
      rx_cc_d    = rx_cc_q;
      ref_vld_d  = ref_vld_q;
      match_d    = match_q;
      pay_flag_d = pay_flag_q;
      locked_d   = locked_q;
      strobe_d   = 1'b0;
      cc_err_d   = 1'b0;
      inc_cc_c   = 1'b0;
      inc_sync_c = 1'b0;
      inc_pay_c  = 1'b0;
      inc_pkt_c  = 1'b0;

      good_sync_c = DVALID & PSYNC & (DATA == SYNC_BYTE);
      idx_nxt_c   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      pay_bad_c   = (PAYLOAD_CHK != 0) && match_q && (DATA != {4'h0, cc_q});
      // A filter change since the last header makes the stored CC reference meaningless
      ref_ok_c    = ref_vld_q && (PID_FILTER == filt_q);

      case (state_q)
         HUNT: begin
            match_d    = 1'b0;
            pay_flag_d = 1'b0;
            if (good_sync_c) begin
               idx_d  = IDX_W'(1);
               good_d = RUN_W'(1);
               if (LOCK_N <= RUN_W'(1)) begin
                  state_d  = LOCK;
                  locked_d = 1'b1;
                  bad_d    = '0;
               end else begin
                  state_d = ACQ;
               end
            end
         end
         ACQ: begin
            match_d    = 1'b0;
            pay_flag_d = 1'b0;
            if (DVALID) begin
               idx_d = idx_nxt_c;
               if (idx_q == '0) begin
                  if (good_sync_c) begin
                     good_d = good_q + RUN_W'(1);
                     if (good_q + RUN_W'(1) >= LOCK_N) begin
                        state_d  = LOCK;
                        locked_d = 1'b1;
                        bad_d    = '0;
                     end
                  end else begin
                     state_d = HUNT;
                     idx_d   = '0;
                  end
               end else if (PSYNC) begin
                  state_d = HUNT;
                  idx_d   = '0;
               end
            end
         end
         LOCK: begin
            if (DVALID) begin
               idx_d = idx_nxt_c;
               if (idx_q == '0) begin
                  match_d    = 1'b0;
                  pay_flag_d = 1'b0;
                  if (good_sync_c) begin
                     bad_d = '0;
                  end else begin
                     inc_sync_c = 1'b1;
                     bad_d      = bad_q + RUN_W'(1);
                     if (bad_q + RUN_W'(1) >= LOSS_N) begin
                        state_d   = HUNT;
                        locked_d  = 1'b0;
                        ref_vld_d = 1'b0;
                        idx_d     = '0;
                     end
                  end
               end else begin
                  if (PSYNC) inc_sync_c = 1'b1;
                  if (idx_q == IDX_W'(1)) pid_d[12:8] = DATA[4:0];
                  if (idx_q == IDX_W'(2)) pid_d[7:0]  = DATA;
                  if (idx_q == IDX_W'(3)) begin
                     cc_d   = DATA[3:0];
                     filt_d = PID_FILTER;
                     if (PID_FILTER != filt_q) ref_vld_d = 1'b0;
                     if (pid_q == PID_FILTER) begin
                        match_d   = 1'b1;
                        ref_cc_d  = DATA[3:0];
                        ref_vld_d = 1'b1;
                        if (ref_ok_c && (DATA[3:0] != ref_cc_q + 4'd1)) begin
                           cc_err_d = 1'b1;
                           inc_cc_c = 1'b1;
                        end
                     end
                  end
                  if ((idx_q >= IDX_W'(4)) && pay_bad_c) pay_flag_d = 1'b1;
                  if (idx_q == IDX_LAST) begin
                     strobe_d  = 1'b1;
                     inc_pkt_c = 1'b1;
                     rx_pid_d  = pid_q;
                     rx_cc_d   = cc_q;
                     if (pay_flag_q || pay_bad_c) inc_pay_c = 1'b1;
                  end
               end
            end
         end
         default: state_d = HUNT;
      endcase

      pkt_cnt_d      = CLR_CNT ? '0 : (inc_pkt_c  ? pkt_cnt_q + PKT_W'(1)  : pkt_cnt_q);
      cc_err_cnt_d   = CLR_CNT ? '0 : (inc_cc_c   ? sat_inc(cc_err_cnt_q)   : cc_err_cnt_q);
      sync_err_cnt_d = CLR_CNT ? '0 : (inc_sync_c ? sat_inc(sync_err_cnt_q) : sync_err_cnt_q);
      pay_err_cnt_d  = CLR_CNT ? '0 : (inc_pay_c  ? sat_inc(pay_err_cnt_q)  : pay_err_cnt_q);
   end

   always_ff @(posedge CLK_IN or negedge RST) begin
      if (!RST) begin
         state_q        <= HUNT;
         idx_q          <= '0;
         good_q         <= '0;
         bad_q          <= '0;
         pid_q          <= '0;
         filt_q         <= '0;
         rx_pid_q       <= '0;
         cc_q           <= '0;
         ref_cc_q       <= '0;
         rx_cc_q        <= '0;
         ref_vld_q      <= 1'b0;
         match_q        <= 1'b0;
         pay_flag_q     <= 1'b0;
         locked_q       <= 1'b0;
         strobe_q       <= 1'b0;
         cc_err_q       <= 1'b0;
         pkt_cnt_q      <= '0;
         cc_err_cnt_q   <= '0;
         sync_err_cnt_q <= '0;
         pay_err_cnt_q  <= '0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         good_q         <= good_d;
         bad_q          <= bad_d;
         pid_q          <= pid_d;
         filt_q         <= filt_d;
         rx_pid_q       <= rx_pid_d;
         cc_q           <= cc_d;
         ref_cc_q       <= ref_cc_d;
         rx_cc_q        <= rx_cc_d;
         ref_vld_q      <= ref_vld_d;
         match_q        <= match_d;
         pay_flag_q     <= pay_flag_d;
         locked_q       <= locked_d;
         strobe_q       <= strobe_d;
         cc_err_q       <= cc_err_d;
         pkt_cnt_q      <= pkt_cnt_d;
         cc_err_cnt_q   <= cc_err_cnt_d;
         sync_err_cnt_q <= sync_err_cnt_d;
         pay_err_cnt_q  <= pay_err_cnt_d;
      end
   end

   assign LOCKED       = locked_q;
   assign RX_PID       = rx_pid_q;
   assign RX_CC        = rx_cc_q;
   assign PKT_STROBE   = strobe_q;
   assign CC_ERR       = cc_err_q;
   assign PKT_CNT      = pkt_cnt_q;
   assign CC_ERR_CNT   = cc_err_cnt_q;
   assign SYNC_ERR_CNT = sync_err_cnt_q;
   assign PAY_ERR_CNT  = pay_err_cnt_q;

endmodule

// File: tb/tb_ts_rx_checker.sv
// Directed bench for ts_rx_checker: packet-level reference model compared every cycle,
// plus literal checkpoints for each scenario.
`timescale 1ns/1ps
module tb_ts_rx_checker;
   localparam int SYNC_LOCK   = 3;
   localparam int SYNC_LOSS   = 3;
   localparam int PAYLOAD_CHK = 1;

   logic        CLK_IN = 1'b0;
   logic        RST;
   logic [7:0]  DATA;
   logic        DVALID, PSYNC, CLR_CNT;
   logic [12:0] PID_FILTER;
   logic        LOCKED, PKT_STROBE, CC_ERR;
   logic [12:0] RX_PID;
   logic [3:0]  RX_CC;
   logic [31:0] PKT_CNT;
   logic [15:0] CC_ERR_CNT, SYNC_ERR_CNT, PAY_ERR_CNT;

   ts_rx_checker #(.SYNC_LOCK(SYNC_LOCK), .SYNC_LOSS(SYNC_LOSS), .PAYLOAD_CHK(PAYLOAD_CHK)) dut (
      .CLK_IN(CLK_IN), .RST(RST), .DATA(DATA), .DVALID(DVALID), .PSYNC(PSYNC),
      .PID_FILTER(PID_FILTER), .CLR_CNT(CLR_CNT), .LOCKED(LOCKED), .RX_PID(RX_PID),
      .RX_CC(RX_CC), .PKT_STROBE(PKT_STROBE), .CC_ERR(CC_ERR), .PKT_CNT(PKT_CNT),
      .CC_ERR_CNT(CC_ERR_CNT), .SYNC_ERR_CNT(SYNC_ERR_CNT), .PAY_ERR_CNT(PAY_ERR_CNT));

   always #5 CLK_IN = ~CLK_IN;

   int total = 0;
   int bad   = 0;
   int cc_pulses = 0;
   int gap_ctr = 0;
   bit gaps = 1'b0;
   logic [3:0] gen_cc = 4'd0;

   // Reference model: 0 = searching, 1 = acquiring, 2 = locked
   int          m_mode, m_idx, m_run, m_miss, m_ref, m_filt_used;
   bit          m_match;
   logic [7:0]  m_pkt [188];
   bit          e_locked, e_strobe, e_ccerr;
   int          e_pid, e_cc, e_ccc, e_sec, e_pec;
   int unsigned e_pkt;

   function automatic int sat16(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_idx = 0; m_run = 0; m_miss = 0; m_ref = -1; m_filt_used = 0; m_match = 0;
      e_locked = 0; e_strobe = 0; e_ccerr = 0; e_pid = 0; e_cc = 0;
      e_pkt = 0; e_ccc = 0; e_sec = 0; e_pec = 0;
   endtask

   task automatic model_step(input logic [7:0] d, input bit ps, input bit v, input int filt, input bit clr);
      bit good, ds, dc, dp, dk;
      int pid;
      good = v && ps && (d == 8'h47);
      e_strobe = 0; e_ccerr = 0; ds = 0; dc = 0; dp = 0; dk = 0;
      if (v) begin
         case (m_mode)
            0: if (good) begin m_mode = 1; m_idx = 1; m_run = 1; end
            1: begin
               if (m_idx == 0) begin
                  if (good) begin
                     m_run++; m_idx = 1;
                     if (m_run == SYNC_LOCK) begin m_mode = 2; m_miss = 0; m_match = 0; end
                  end else begin
                     m_mode = 0; m_idx = 0;
                  end
               end else if (ps) begin
                  m_mode = 0; m_idx = 0;
               end else begin
                  m_idx = (m_idx + 1) % 188;
               end
            end
            default: begin
               m_pkt[m_idx] = d;
               if (m_idx == 0) begin
                  m_match = 0;
                  if (good) m_miss = 0;
                  else begin ds = 1; m_miss++; end
               end else begin
                  if (ps) ds = 1;
                  if (m_idx == 3) begin
                     pid = {m_pkt[1][4:0], m_pkt[2]};
                     if (filt != m_filt_used) m_ref = -1;
                     m_filt_used = filt;
                     m_match = (pid == filt);
                     if (m_match) begin
                        if (m_ref >= 0 && int'(d % 16) != (m_ref + 1) % 16) begin e_ccerr = 1; dc = 1; end
                        m_ref = int'(d % 16);
                     end
                  end
                  if (m_idx == 187) begin
                     e_pid = {m_pkt[1][4:0], m_pkt[2]};
                     e_cc = int'(m_pkt[3] % 16);
                     e_strobe = 1; dk = 1;
                     if (m_match && PAYLOAD_CHK != 0)
                        for (int i = 4; i < 188; i++) if (m_pkt[i] != m_pkt[3] % 16) dp = 1;
                  end
               end
               if (m_miss == SYNC_LOSS) begin m_mode = 0; m_idx = 0; m_ref = -1; m_miss = 0; end
               else m_idx = (m_idx + 1) % 188;
            end
         endcase
      end
      if (clr) begin
         e_pkt = 0; e_ccc = 0; e_sec = 0; e_pec = 0;
      end else begin
         if (dk) e_pkt = e_pkt + 1;
         if (dc) e_ccc = sat16(e_ccc);
         if (ds) e_sec = sat16(e_sec);
         if (dp) e_pec = sat16(e_pec);
      end
      e_locked = (m_mode == 2);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic compare_all();
      check("LOCKED",       32'(LOCKED),       32'(e_locked));
      check("RX_PID",       32'(RX_PID),       32'(e_pid));
      check("RX_CC",        32'(RX_CC),        32'(e_cc));
      check("PKT_STROBE",   32'(PKT_STROBE),   32'(e_strobe));
      check("CC_ERR",       32'(CC_ERR),       32'(e_ccerr));
      check("PKT_CNT",      PKT_CNT,           e_pkt);
      check("CC_ERR_CNT",   32'(CC_ERR_CNT),   32'(e_ccc));
      check("SYNC_ERR_CNT", 32'(SYNC_ERR_CNT), 32'(e_sec));
      check("PAY_ERR_CNT",  32'(PAY_ERR_CNT),  32'(e_pec));
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after it
   task automatic tick(input logic [7:0] d, input bit ps, input bit v, input bit clr);
      DATA = d; PSYNC = ps; DVALID = v; CLR_CNT = clr;
      @(posedge CLK_IN);
      model_step(d, ps, v, int'(PID_FILTER), clr);
      #1;
      compare_all();
      if (CC_ERR) cc_pulses++;
   endtask

   task automatic send_byte(input logic [7:0] d, input bit ps, input bit clr);
      if (gaps) begin
         gap_ctr++;
         if (gap_ctr % 4 == 0) tick(8'h47, 1'b1, 1'b0, 1'b0);
      end
      tick(d, ps, 1'b1, clr);
   endtask

   task automatic send_pkt(input logic [12:0] pid, input logic [3:0] cc, input logic [7:0] sync_val,
                           input int flip_a, input int flip_b, input bit clr_last, input int psync_at,
                           input int len);
      logic [7:0] b;
      for (int i = 0; i < len; i++) begin
         case (i)
            0:       b = sync_val;
            1:       b = {3'b010, pid[12:8]};
            2:       b = pid[7:0];
            3:       b = {4'h1, cc};
            default: b = {4'h0, cc};
         endcase
         if (i == flip_a || i == flip_b) b = b ^ 8'h81;
         send_byte(b, (i == 0) || (i == psync_at), (i == 187) && clr_last);
      end
   endtask

   task automatic send_one(input logic [7:0] sync_val, input int fa, input int fb,
                           input bit clr_last, input int psync_at);
      send_pkt(13'h100, gen_cc, sync_val, fa, fb, clr_last, psync_at, 188);
      gen_cc = gen_cc + 4'd1;
   endtask

   task automatic send_auto(input int n);
      for (int k = 0; k < n; k++) send_one(8'h47, -1, -1, 1'b0, -1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      RST = 1'b0; DATA = '0; DVALID = 1'b0; PSYNC = 1'b0; CLR_CNT = 1'b0; PID_FILTER = 13'h100;
      model_reset();
      repeat (3) @(posedge CLK_IN);
      #1;
      compare_all();
      check("reset_locked", 32'(LOCKED), 32'd0);
      check("reset_pkt_cnt", PKT_CNT, 32'd0);
      RST = 1'b1;

      // Clean stream: lock on the third sync, so packets 3..10 complete while locked
      send_auto(10);
      check("t1_locked", 32'(LOCKED), 32'd1);
      check("t1_pkt_cnt", PKT_CNT, 32'd8);
      check("t1_rx_pid", 32'(RX_PID), 32'h100);
      check("t1_rx_cc", 32'(RX_CC), 32'd9);
      check("t1_err_sum", 32'(CC_ERR_CNT) + 32'(SYNC_ERR_CNT) + 32'(PAY_ERR_CNT), 32'd0);

      // Single bad sync byte and a stray PSYNC mid-packet
      tick(8'h00, 1'b0, 1'b0, 1'b1);
      send_one(8'h46, -1, -1, 1'b0, -1);
      check("t2_sync_err", 32'(SYNC_ERR_CNT), 32'd1);
      check("t2_locked", 32'(LOCKED), 32'd1);
      send_one(8'h47, -1, -1, 1'b0, 50);
      send_auto(1);
      check("t2_sync_err_psync", 32'(SYNC_ERR_CNT), 32'd2);

      // Three consecutive bad syncs drop lock; three good packets re-lock
      tick(8'h00, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) send_one(8'h46, -1, -1, 1'b0, -1);
      check("t3_sync_err", 32'(SYNC_ERR_CNT), 32'd3);
      check("t3_unlocked", 32'(LOCKED), 32'd0);
      check("t3_pkt_cnt_lost", PKT_CNT, 32'd2);
      send_auto(3);
      check("t3_relocked", 32'(LOCKED), 32'd1);
      check("t3_pkt_cnt", PKT_CNT, 32'd3);

      // Clear on the final byte wins over the increment; CC 14,15,0 then skip to 2
      send_one(8'h47, -1, -1, 1'b1, -1);
      check("t4_clr_beats_inc", PKT_CNT, 32'd0);
      while (gen_cc != 4'd14) send_auto(1);
      tick(8'h00, 1'b0, 1'b0, 1'b1);
      cc_pulses = 0;
      send_auto(3);
      check("t4_wrap_ok", 32'(CC_ERR_CNT), 32'd0);
      gen_cc = 4'd2;
      send_auto(2);
      check("t4_cc_err_cnt", 32'(CC_ERR_CNT), 32'd1);
      check("t4_cc_pulses", 32'(cc_pulses), 32'd1);
      check("t4_rx_cc", 32'(RX_CC), 32'd3);

      // Payload flips (including the last byte); other PID errors are ignored
      tick(8'h00, 1'b0, 1'b0, 1'b1);
      send_one(8'h47, 10, 187, 1'b0, -1);
      check("t5_pay_err", 32'(PAY_ERR_CNT), 32'd1);
      send_pkt(13'h0A5, 4'd7, 8'h47, 20, 30, 1'b0, -1, 188);
      send_pkt(13'h0A5, 4'd7, 8'h47, 40, -1, 1'b0, -1, 188);
      check("t5_rx_pid_other", 32'(RX_PID), 32'h0A5);
      send_auto(1);
      PID_FILTER = 13'h0A5;
      send_pkt(13'h0A5, 4'd3, 8'h47, -1, -1, 1'b0, -1, 188);
      send_pkt(13'h0A5, 4'd4, 8'h47, -1, -1, 1'b0, -1, 188);
      PID_FILTER = 13'h100;
      gen_cc = gen_cc + 4'd5;
      send_auto(2);
      check("t5_cc_err_none", 32'(CC_ERR_CNT), 32'd0);
      check("t5_pay_err_once", 32'(PAY_ERR_CNT), 32'd1);

      // Reset mid-packet, then a gapped stream re-locks cleanly
      send_pkt(13'h100, gen_cc, 8'h47, -1, -1, 1'b0, -1, 100);
      RST = 1'b0;
      model_reset();
      #1;
      compare_all();
      check("t6_rst_locked", 32'(LOCKED), 32'd0);
      check("t6_rst_sync_err", 32'(SYNC_ERR_CNT), 32'd0);
      repeat (2) begin
         @(posedge CLK_IN);
         #1;
         compare_all();
      end
      RST = 1'b1;
      gaps = 1'b1;
      gen_cc = 4'd0;
      send_auto(5);
      check("t6_locked", 32'(LOCKED), 32'd1);
      check("t6_pkt_cnt", PKT_CNT, 32'd3);
      check("t6_rx_cc", 32'(RX_CC), 32'd4);
      check("t6_err_sum", 32'(CC_ERR_CNT) + 32'(SYNC_ERR_CNT) + 32'(PAY_ERR_CNT), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
